// File: rtl/venus_pkg.sv
// Shared definitions for the venus front end.
// Holds the datapath widths, the fetch queue depth and the fetch queue entry type
// used by fetch_unit and fetch_queue.
package venus_pkg;

  localparam int unsigned PC_W        = 16;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned FETCH_DEPTH = 2;
  localparam int unsigned ENTRY_W     = PC_W + INST_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetched {pc, inst} entries, head exposed combinationally.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (clears storage and count)
//   flush_i        empties the queue; overrides push and pop in the same cycle
//   push_i         write push_data_i at the tail (caller guarantees room)
//   push_data_i    entry to write, packed fetch_entry_t
//   pop_i          remove the head; ignored while empty
//   valid_o        head entry present
//   head_o         head entry, packed fetch_entry_t
//   count_o        number of stored entries (0..2)
module fetch_queue
  import venus_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic               valid_o,
  output logic [ENTRY_W-1:0] head_o,
  output logic [1:0]         count_o
);

  fetch_entry_t ent_q [FETCH_DEPTH];
  fetch_entry_t ent_d [FETCH_DEPTH];
  logic [1:0]   count_q, count_d;
  fetch_entry_t push_entry;
  logic         pop;

  assign push_entry = fetch_entry_t'(push_data_i);
  assign pop        = pop_i && (count_q != 2'd0);

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({push_i, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            ent_d[0] = ent_q[1];
            ent_d[1] = push_entry;
          end else begin
            ent_d[0] = push_entry;
          end
        end
        2'b01: begin
          ent_d[0] = ent_q[1];
          count_d  = count_q - 2'd1;
        end
        2'b10: begin
          ent_d[count_q[0]] = push_entry;
          count_d           = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      count_q  <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign head_o  = ent_q[0];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory and
// buffers returned words in a 2-entry queue toward decode. A redirect reloads the PC
// and discards everything fetched down the old path.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   redirect_i         qualified taken branch from execute
//   redirect_addr_i    branch destination, only [15:0] used
//   imem_req_o         read request; imem_addr_o is its word address
//   imem_ready_i       memory accepts the request this cycle
//   imem_rvalid_i      read data valid (in issue order); imem_rdata_i instruction word
//   inst_valid_o       queue head valid; inst_o / inst_pc_o head instruction and its PC
//   inst_ready_i       decode consumes the head
module fetch_unit
  import venus_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_addr_i,
  output logic              imem_req_o,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic              imem_ready_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   inst_pc_o,
  input  logic              inst_ready_i
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [1:0]         pending_q, pending_d;
  logic [1:0]         kill_q, kill_d;
  // PCs of live (not killed) in-flight requests, oldest in slot 0.
  logic [PC_W-1:0]    shadow_q [FETCH_DEPTH];
  logic [PC_W-1:0]    shadow_d [FETCH_DEPTH];

  logic [1:0]         q_count;
  logic [ENTRY_W-1:0] q_head;
  logic [1:0]         live;
  logic               live_idx;
  logic               issued;
  logic               rsp, rsp_live, rsp_drop;
  logic [15:0]        unused_addr_hi;

  assign unused_addr_hi = redirect_addr_i[31:16];

  // Credit check uses registered counts only, so decode's ready never reaches the request.
  assign imem_req_o  = !rst_i && !redirect_i &&
                       ((3'(pending_q) + 3'(q_count)) < 3'(FETCH_DEPTH));
  assign imem_addr_o = pc_q;
  assign issued      = imem_req_o && imem_ready_i;

  // A stray response with nothing outstanding is not tracked.
  assign rsp      = imem_rvalid_i && (pending_q != 2'd0);
  assign rsp_drop = rsp && (kill_q != 2'd0);
  assign rsp_live = rsp && (kill_q == 2'd0);

  assign live     = pending_q - kill_q;
  // Issue only happens with at most one live request left, so one bit indexes the slot.
  assign live_idx = 1'(live - {1'b0, rsp_live});

  always_comb begin
    pc_d      = pc_q;
    pending_d = pending_q;
    kill_d    = kill_q;
    shadow_d  = shadow_q;
    if (redirect_i) begin
      // Everything still outstanding belongs to the old path.
      pc_d      = redirect_addr_i[PC_W-1:0];
      pending_d = pending_q - {1'b0, rsp};
      kill_d    = pending_q - {1'b0, rsp};
    end else begin
      if (issued) begin
        pc_d = pc_q + PC_W'(1);
      end
      pending_d = pending_q + {1'b0, issued} - {1'b0, rsp};
      if (rsp_drop) begin
        kill_d = kill_q - 2'd1;
      end
      if (rsp_live) begin
        shadow_d[0] = shadow_q[1];
      end
      if (issued) begin
        shadow_d[live_idx] = pc_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      pending_q   <= 2'd0;
      kill_q      <= 2'd0;
      shadow_q[0] <= '0;
      shadow_q[1] <= '0;
    end else begin
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      kill_q      <= kill_d;
      shadow_q    <= shadow_d;
    end
  end

  fetch_queue u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (rsp_live && !redirect_i),
    .push_data_i ({shadow_q[0], imem_rdata_i}),
    .pop_i       (inst_ready_i && !redirect_i),
    .valid_o     (inst_valid_o),
    .head_o      (q_head),
    .count_o     (q_count)
  );

  assign inst_pc_o = q_head[ENTRY_W-1:INST_W];
  assign inst_o    = q_head[INST_W-1:0];

endmodule
